// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads instruction memory and hands {pc, instr} to decode.
// Optional FETCH_PERF_EN adds saturating fetch/stall counters.
module instruction_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'd0,
  parameter logic [63:0] PC_LIMIT = 64'd84
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [63:0] Instr_Addr,
  input  logic [31:0] Instruction,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr,
  output logic        halted,
`ifdef FETCH_PERF_EN
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count,
`endif
  output logic        fault
);

  typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

  state_t      state;
  logic [63:0] pc;
  logic        adv;
  logic        at_limit;
  logic        misaligned;
  logic        capture;

  assign Instr_Addr = pc;
  assign adv        = !out_valid || out_ready;
  assign at_limit   = (pc >= PC_LIMIT);
  assign misaligned = (redirect_target[1:0] != 2'b00);
  assign capture    = (state == FETCH) && !redirect_valid && !at_limit && adv;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      out_valid <= 1'b0;
      out_pc    <= 64'd0;
      out_instr <= 32'd0;
      halted    <= 1'b0;
      fault     <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (redirect_valid) begin
            // Redirect flushes the output stage and beats both back-pressure and the limit check.
            out_valid <= 1'b0;
            if (misaligned) begin
              fault  <= 1'b1;
              state  <= HALT;
              halted <= 1'b1;
            end else begin
              pc <= redirect_target;
            end
          end else if (at_limit) begin
            state  <= HALT;
            halted <= 1'b1;
            if (out_ready) out_valid <= 1'b0;
          end else if (capture) begin
            out_pc    <= pc;
            out_instr <= Instruction;
            out_valid <= 1'b1;
            pc        <= pc + 64'd4;
          end
        end
        HALT: begin
          // A still-pending output drains to decode before out_valid falls.
          if (out_ready) out_valid <= 1'b0;
          if (redirect_valid) begin
            if (misaligned) begin
              fault <= 1'b1;
            end else begin
              pc        <= redirect_target;
              state     <= FETCH;
              halted    <= 1'b0;
              out_valid <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic stall;
  assign stall = (state == FETCH) && out_valid && !out_ready && !redirect_valid;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fetch_count <= 32'd0;
      stall_count <= 32'd0;
    end else begin
      if (capture) fetch_count <= sat_inc(fetch_count);
      if (stall)   stall_count <= sat_inc(stall_count);
    end
  end
`endif

endmodule
